// File: rtl/adder_result_accumulator_if.sv
// Beat-in / total-out handshake bundle for adder_result_accumulator.
// master drives beats, start and out_ready; slave is the accumulator.
interface adder_result_accumulator_if #(
  parameter int unsigned ACC_W = 8,
  parameter int unsigned BEATS = 4
);
  localparam int unsigned CntW = $clog2(BEATS + 1);

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       z;
  logic             carry;
  logic [ACC_W-1:0] acc_out;
  logic [CntW-1:0]  beat_cnt;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output start, in_valid, z, carry, out_ready,
    input  in_ready, acc_out, beat_cnt, overflow, out_valid
  );

  modport slave (
    input  start, in_valid, z, carry, out_ready,
    output in_ready, acc_out, beat_cnt, overflow, out_valid
  );
endinterface

// File: rtl/adder_result_accumulator.sv
// Sums BEATS 3-bit {carry, z} beats into an ACC_W-bit total with sticky overflow.
// Define ACC_SATURATE_EN to clamp the total on overflow instead of wrapping.
module adder_result_accumulator #(
  parameter int unsigned ACC_W = 8,
  parameter int unsigned BEATS = 4
) (
  input logic                         clk,
  input logic                         reset,
  adder_result_accumulator_if.slave   bus
);
  localparam int unsigned CntW = $clog2(BEATS + 1);
  localparam logic [ACC_W-1:0] AccMax = '1;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [ACC_W-1:0] r_acc, w_acc_next;
  logic [CntW-1:0]  r_cnt, w_cnt_next;
  logic             r_ovf, w_ovf_next;
  logic             w_accept;
  logic [ACC_W:0]   w_sum;

  assign w_accept = (r_state == StAccum) && bus.in_valid;
  // One spare bit on the adder catches the carry-out that marks overflow.
  assign w_sum    = {1'b0, r_acc} + (ACC_W + 1)'({bus.carry, bus.z});

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_ovf;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_acc_next   = '0;
          w_cnt_next   = '0;
          w_ovf_next   = 1'b0;
          w_state_next = StAccum;
        end
      end
      StAccum: begin
        if (w_accept) begin
          w_cnt_next = r_cnt + CntW'(1);
          w_ovf_next = r_ovf | w_sum[ACC_W];
`ifdef ACC_SATURATE_EN
          w_acc_next = (r_ovf || w_sum[ACC_W]) ? AccMax : w_sum[ACC_W-1:0];
`else
          w_acc_next = w_sum[ACC_W-1:0];
`endif
          if (w_cnt_next == CntW'(BEATS)) begin
            w_state_next = StDone;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign bus.in_ready  = (r_state == StAccum);
  assign bus.out_valid = (r_state == StDone);
  assign bus.acc_out   = r_acc;
  assign bus.beat_cnt  = r_cnt;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_adder_result_accumulator.sv
// Drives an 8-bit and a 4-bit accumulator with identical beats and checks both
// against an exact-sum reference model (wrap or clamp chosen by ACC_SATURATE_EN).
module tb_adder_result_accumulator;
  localparam int unsigned NB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       t_start, t_valid, t_ordy;
  logic [2:0] t_beat;
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         sat;

  always #5 clk = ~clk;

  adder_result_accumulator_if #(.ACC_W(8), .BEATS(NB)) if8 ();
  adder_result_accumulator_if #(.ACC_W(4), .BEATS(NB)) if4 ();

  assign if8.start     = t_start;
  assign if8.in_valid  = t_valid;
  assign if8.z         = t_beat[1:0];
  assign if8.carry     = t_beat[2];
  assign if8.out_ready = t_ordy;
  assign if4.start     = t_start;
  assign if4.in_valid  = t_valid;
  assign if4.z         = t_beat[1:0];
  assign if4.carry     = t_beat[2];
  assign if4.out_ready = t_ordy;

  adder_result_accumulator #(.ACC_W(8), .BEATS(NB)) dut8 (.clk(clk), .reset(reset), .bus(if8));
  adder_result_accumulator #(.ACC_W(4), .BEATS(NB)) dut4 (.clk(clk), .reset(reset), .bus(if4));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_acc(input int w, input longint exact);
    longint max = (longint'(1) << w) - 1;
    if (exact <= max) return exact;
    return sat ? max : exact % (max + 1);
  endfunction

  task automatic check_all(input string tag, input longint exact, input int cnt,
                           input bit ir, input bit ov);
    check({tag, "/acc8"}, if8.acc_out, model_acc(8, exact));
    check({tag, "/ovf8"}, if8.overflow, exact > 255);
    check({tag, "/cnt8"}, if8.beat_cnt, cnt);
    check({tag, "/ir8"},  if8.in_ready, ir);
    check({tag, "/ov8"},  if8.out_valid, ov);
    check({tag, "/acc4"}, if4.acc_out, model_acc(4, exact));
    check({tag, "/ovf4"}, if4.overflow, exact > 15);
    check({tag, "/cnt4"}, if4.beat_cnt, cnt);
    check({tag, "/ir4"},  if4.in_ready, ir);
    check({tag, "/ov4"},  if4.out_valid, ov);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gaps[i] idle cycles precede beat i; poke pulses start mid-run and in DONE.
  task automatic run(input string tag, input int beats[$], input int gaps[$],
                     input bit early_ordy, input int hold, input bit poke);
    longint exact = 0;
    int     cnt   = 0;
    t_ordy  = early_ordy;
    t_start = 1'b1;
    step();
    t_start = 1'b0;
    check_all({tag, ":start"}, 0, 0, 1, 0);
    for (int i = 0; i < NB; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        t_valid = 1'b0;
        step();
        check_all({tag, ":gap"}, exact, cnt, 1, 0);
      end
      if (poke && i == 2) begin
        t_start = 1'b1;
        step();
        t_start = 1'b0;
        check_all({tag, ":ign_start"}, exact, cnt, 1, 0);
      end
      t_valid = 1'b1;
      t_beat  = 3'(beats[i]);
      step();
      t_valid = 1'b0;
      exact += beats[i];
      cnt++;
      check_all({tag, ":beat"}, exact, cnt, cnt < NB, cnt == NB);
    end
    if (!early_ordy) begin
      for (int k = 0; k < hold; k++) begin
        t_start = poke && (k == 1);
        step();
        t_start = 1'b0;
        check_all({tag, ":hold"}, exact, cnt, 0, 1);
      end
      t_ordy = 1'b1;
    end
    step();
    t_ordy = 1'b0;
    check_all({tag, ":idle"}, exact, cnt, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int qb[$];
    int qg[$];
`ifdef ACC_SATURATE_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    reset = 1'b1; t_start = 1'b0; t_valid = 1'b0; t_ordy = 1'b0; t_beat = '0;
    step();
    step();
    reset = 1'b0;
    check_all("por", 0, 0, 0, 0);

    qb = '{3, 7, 1, 5}; qg = '{0, 0, 0, 0};
    run("basic", qb, qg, 1'b0, 1, 1'b0);
    qb = '{7, 7, 7, 7};
    run("overflow", qb, qg, 1'b0, 0, 1'b0);
    qb = '{2, 2, 2, 2}; qg = '{0, 2, 0, 1};
    run("stall", qb, qg, 1'b0, 5, 1'b0);
    qb = '{1, 1, 1, 1}; qg = '{0, 0, 0, 0};
    run("ignstart", qb, qg, 1'b0, 3, 1'b1);
    qb = '{6, 0, 5, 4};
    run("early_ordy", qb, qg, 1'b1, 0, 1'b0);

    // Abandon a run after two beats.
    t_start = 1'b1;
    step();
    t_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      t_valid = 1'b1;
      t_beat  = 3'd5;
      step();
    end
    t_valid = 1'b0;
    check_all("pre_reset", 10, 2, 1, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all("mid_reset", 0, 0, 0, 0);
    qb = '{1, 2, 3, 4};
    run("after_reset", qb, qg, 1'b0, 0, 1'b0);

    reset   = 1'b1;
    t_start = 1'b1;
    step();
    reset   = 1'b0;
    t_start = 1'b0;
    check_all("reset_wins", 0, 0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      qb.delete();
      qg.delete();
      for (int i = 0; i < NB; i++) begin
        qb.push_back($urandom_range(0, 7));
        qg.push_back($urandom_range(0, 2));
      end
      run("rand", qb, qg, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
          1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
